multicycle_controller: RTL and testbench

//  Control FSM that sequences a multicycle MIPS datapath. The datapath uses a shared ALU and one

---
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS datapath with a shared ALU and one unified memory.
// Steps each instruction through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             funct_ok;
  logic             retire;

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW)           state_next = MEMADR;
        else if (op == OP_RTYPE && funct_ok)      state_next = EXECUTE;
        else if (op == OP_BEQ)                    state_next = BRANCH;
        else if (op == OP_ADDI)                   state_next = ADDIEX;
        else if (op == OP_J)                      state_next = JUMP;
        else                                      state_next = FETCH;
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWRITE: if (mem_ready) begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      EXECUTE:  state_next = ALUWB;
      ADDIEX:   state_next = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      default:  state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Outputs follow the state, but every one of them is held at 0 while reset is asserted.
  always_comb begin
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = 3'b000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    if (rst_n) begin
      case (state_reg)
        FETCH: begin
          mem_req     = 1'b1;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
          alu_src_b   = 2'b01;
          alu_control = 3'b010;
        end
        DECODE: begin
          alu_src_b     = 2'b11;
          alu_control   = 3'b010;
          illegal_instr = (state_next == FETCH);
        end
        MEMADR, ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = 3'b010;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          case (funct)
            6'b100010: alu_control = 3'b110;
            6'b100100: alu_control = 3'b000;
            6'b100101: alu_control = 3'b001;
            6'b101010: alu_control = 3'b111;
            default:   alu_control = 3'b010;
          endcase
        end
        ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = 3'b110;
          branch      = 1'b1;
          pc_src      = 2'b01;
        end
        ADDIWB: reg_write = 1'b1;
        JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_count = count_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table plus reset and counter-wrap sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_control;
  logic       reg_dst, mem_to_reg, reg_write, illegal_instr;
  logic [3:0] instr_count;
  logic [3:0] state_o;

  multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .instr_count(instr_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [17:0] act_ctl;
  assign act_ctl = {mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
                    alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, illegal_instr};

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [17:0] mk(input logic mr, io, mw, irw, pcw, br, input logic [1:0] ps,
                                     input logic a, input logic [1:0] b, input logic [2:0] alu,
                                     input logic rd, m2r, rw, ill);
    return {mr, io, mw, irw, pcw, br, ps, a, b, alu, rd, m2r, rw, ill};
  endfunction

  task automatic add(input string n, input logic [5:0] o, input logic [5:0] f, input logic r,
                     input logic [3:0] s, input logic [17:0] c, input logic [3:0] k);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.rdy = r; v.st = s; v.ctl = c; v.cnt = k;
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input logic [3:0] s, input logic [17:0] c, input logic [3:0] k);
    checks++;
    if (state_o !== s) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", n, state_o, s);
    end
    checks++;
    if (act_ctl !== c) begin
      errors++;
      $display("FAIL %s ctrl: got %b want %b", n, act_ctl, c);
    end
    checks++;
    if (instr_count !== k) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", n, instr_count, k);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, check, then wait out the rising edge.
  task automatic step(input string n, input logic [5:0] o, input logic [5:0] f, input logic r,
                      input logic [3:0] s, input logic [17:0] c, input logic [3:0] k);
    op = o; funct = f; mem_ready = r;
    #1;
    check(n, s, c, k);
    $display("step %-12s op=%b funct=%b rdy=%b state=%0d ctl=%b cnt=%0d", n, o, f, r, state_o, act_ctl, instr_count);
    @(negedge clk);
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  logic [17:0] c_f1, c_f0, c_dec, c_deci, c_adr, c_mrd, c_mwb, c_mwr, c_awb, c_br, c_iwb, c_jmp;

  initial begin
    c_f1   = mk(1,0,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0);
    c_f0   = mk(1,0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0);
    c_dec  = mk(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0);
    c_deci = mk(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,1);
    c_adr  = mk(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
    c_mrd  = mk(1,1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
    c_mwb  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,1,0);
    c_mwr  = mk(1,1,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
    c_awb  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,0);
    c_br   = mk(0,0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,0,0);
    c_iwb  = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0);
    c_jmp  = mk(0,0,0,0,1,0,2'b10,0,2'b00,3'b000,0,0,0,0);

    // R-type: add, sub, and, or, slt
    add("add.f",  R, 6'b100000, 1, 0, c_f1, 0);
    add("add.d",  R, 6'b100000, 1, 1, c_dec, 0);
    add("add.ex", R, 6'b100000, 1, 6, mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0,0), 0);
    add("add.wb", R, 6'b100000, 1, 7, c_awb, 0);
    add("sub.f",  R, 6'b100010, 1, 0, c_f1, 1);
    add("sub.d",  R, 6'b100010, 1, 1, c_dec, 1);
    add("sub.ex", R, 6'b100010, 1, 6, mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b110,0,0,0,0), 1);
    add("sub.wb", R, 6'b100010, 1, 7, c_awb, 1);
    add("and.f",  R, 6'b100100, 1, 0, c_f1, 2);
    add("and.d",  R, 6'b100100, 1, 1, c_dec, 2);
    add("and.ex", R, 6'b100100, 1, 6, mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b000,0,0,0,0), 2);
    add("and.wb", R, 6'b100100, 1, 7, c_awb, 2);
    add("or.f",   R, 6'b100101, 1, 0, c_f1, 3);
    add("or.d",   R, 6'b100101, 1, 1, c_dec, 3);
    add("or.ex",  R, 6'b100101, 1, 6, mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b001,0,0,0,0), 3);
    add("or.wb",  R, 6'b100101, 1, 7, c_awb, 3);
    add("slt.f",  R, 6'b101010, 1, 0, c_f1, 4);
    add("slt.d",  R, 6'b101010, 1, 1, c_dec, 4);
    add("slt.ex", R, 6'b101010, 1, 6, mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b111,0,0,0,0), 4);
    add("slt.wb", R, 6'b101010, 1, 7, c_awb, 4);
    // addi with one stalled fetch cycle
    add("addi.f0", ADDI, 6'd0, 0, 0, c_f0, 5);
    add("addi.f",  ADDI, 6'd0, 1, 0, c_f1, 5);
    add("addi.d",  ADDI, 6'd0, 1, 1, c_dec, 5);
    add("addi.ex", ADDI, 6'd0, 1, 9, c_adr, 5);
    add("addi.wb", ADDI, 6'd0, 1, 10, c_iwb, 5);
    // lw with three wait cycles in MEMREAD: 8 cycles total
    add("lw.f",   LW, 6'd0, 1, 0, c_f1, 6);
    add("lw.d",   LW, 6'd0, 1, 1, c_dec, 6);
    add("lw.adr", LW, 6'd0, 1, 2, c_adr, 6);
    add("lw.rd0", LW, 6'd0, 0, 3, c_mrd, 6);
    add("lw.rd1", LW, 6'd0, 0, 3, c_mrd, 6);
    add("lw.rd2", LW, 6'd0, 0, 3, c_mrd, 6);
    add("lw.rd3", LW, 6'd0, 1, 3, c_mrd, 6);
    add("lw.wb",  LW, 6'd0, 1, 4, c_mwb, 6);
    // sw with one wait cycle
    add("sw.f",   SW, 6'd0, 1, 0, c_f1, 7);
    add("sw.d",   SW, 6'd0, 1, 1, c_dec, 7);
    add("sw.adr", SW, 6'd0, 1, 2, c_adr, 7);
    add("sw.wr0", SW, 6'd0, 0, 5, c_mwr, 7);
    add("sw.wr1", SW, 6'd0, 1, 5, c_mwr, 7);
    // beq, then two illegal encodings that must not count
    add("beq.f",  BEQ, 6'd0, 1, 0, c_f1, 8);
    add("beq.d",  BEQ, 6'd0, 1, 1, c_dec, 8);
    add("beq.br", BEQ, 6'd0, 1, 8, c_br, 8);
    add("ill1.f", BAD, 6'd0, 1, 0, c_f1, 9);
    add("ill1.d", BAD, 6'd0, 1, 1, c_deci, 9);
    add("ill2.f", R,   6'd0, 1, 0, c_f1, 9);
    add("ill2.d", R,   6'd0, 1, 1, c_deci, 9);
    add("end.f",  LW,  6'd0, 1, 0, c_f1, 9);

    rst_n = 1'b0; op = '0; funct = '0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset.init", 4'd0, 18'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].rdy, tbl[i].st, tbl[i].ctl, tbl[i].cnt);

    // Abandon an lw stalled in MEMREAD via reset
    step("rst.d",   LW, 6'd0, 1, 1, c_dec, 9);
    step("rst.adr", LW, 6'd0, 1, 2, c_adr, 9);
    step("rst.rd",  LW, 6'd0, 0, 3, c_mrd, 9);
    rst_n = 1'b0;
    #1;
    check("rst.assert", 4'd0, 18'd0, 4'd0);
    $display("step %-12s state=%0d ctl=%b cnt=%0d", "rst.assert", state_o, act_ctl, instr_count);
    @(negedge clk);
    check("rst.hold", 4'd0, 18'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 16 jumps with a 4-bit counter: reads 15 after 15 jumps, wraps to 0 after the 16th
    for (int k = 0; k < 16; k++) begin
      step("j.f",   J, 6'd0, 1, 0,  c_f1,  4'(k));
      step("j.d",   J, 6'd0, 1, 1,  c_dec, 4'(k));
      step("j.jmp", J, 6'd0, 1, 11, c_jmp, 4'(k));
    end
    step("j.wrap", J, 6'd0, 1, 0, c_f1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
